pipe_skid_buffer: RTL and testbench
===================================

# pipe_skid_buffer

Two-entry valid/ready skid buffer for one stage boundary of the out-of-order pipeline. The upstream stage writes into it and the downstream stage reads from it. `in_ready` is a pure function of registered state, so no combinational path runs from `out_ready` back to `in_ready` and backpressure can cross the stage without extending the critical path. Full throughput (one transfer per cycle) is sustained whenever the consumer is ready.

## Interface
Parameters:
- `WIDTH`, default 74: payload width in bits.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: upstream has a payload on `in_data`.
- `in_data`, input, WIDTH: upstream payload.
- `in_ready`, output, 1: buffer accepts a payload this cycle.
- `out_valid`, output, 1: `out_data` holds a valid payload.
- `out_data`, output, WIDTH: payload presented downstream, driven directly from the main register.
- `out_ready`, input, 1: downstream consumes the payload this cycle.
- `count`, output, 2: occupancy, 0 to 2.
- `flush`, input, 1: discard all contents; present only with `PIPE_SKID_FLUSH_EN`.

## Operation
- Storage: main register M (drives `out_data`) and skid register S.
- Three states:
  - EMPTY: `count`=0.
  - ONE: M valid, `count`=1.
  - TWO: M and S valid, `count`=2.
- Handshake signals:
  - Input transfer (`in_xfer`) = `in_valid & in_ready`.
  - Output transfer (`out_xfer`) = `out_valid & out_ready`.
- Combinational outputs, from state only:
  - `out_valid` = state != EMPTY.
  - `in_ready` = (state != TWO) & ~`reset`.
- Transitions:
  - EMPTY, with `in_xfer`: M <= `in_data`, go to ONE. Otherwise stay in EMPTY. `out_ready` is ignored.
  - ONE, with `in_xfer` & `out_xfer`: M <= `in_data`, stay in ONE.
  - ONE, with `in_xfer` & ~`out_xfer`: S <= `in_data`, go to TWO.
  - ONE, with ~`in_xfer` & `out_xfer`: go to EMPTY.
  - ONE, with neither: hold.
  - TWO, with `out_xfer`: M <= S, go to ONE. `in_valid` is ignored because `in_ready` is 0.
  - TWO, without `out_xfer`: hold.
- Ordering: strict FIFO. No payload is duplicated or dropped except by reset or flush.
- Payload registers load only on the conditions above. Invalid slots hold stale data, which is don't-care.
- Priority: `reset` > `flush` > normal operation.

## Timing
- Latency: a payload accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N (a one-cycle stage).
- Throughput: one transfer per cycle in ONE while `in_valid` and `out_ready` are both held high.
- Backpressure:
  - `in_ready` falls the cycle after the first refused output while a new payload is accepted (ONE -> TWO).
  - `in_ready` rises the cycle after the `out_xfer` in TWO.
- Reset: a cycle with `reset`=1 forces, at the edge:
  - state EMPTY, `count`=0, M=0, S=0.
  - Outputs after that edge: `out_valid`=0, `out_data`=0.
  - `in_ready`=0 during the reset cycle itself and 1 afterwards.
  - An `in_valid` presented during reset is not accepted.
  - Reset asserted mid-stream, in ONE or TWO, discards both entries.
- Simultaneous `in_xfer` and `out_xfer` in ONE: the new payload replaces M, `count` stays 1.

## Configuration
- `PIPE_SKID_FLUSH_EN` defined:
  - The `flush` port exists.
  - `flush`=1 at an edge forces EMPTY (`count`=0, `out_valid`=0 afterwards).
  - Any `in_xfer` in the same cycle is dropped, and `in_ready` stays as computed from state.
  - Any `out_xfer` in the same cycle still counts as consumed by downstream.
  - M and S are not cleared.
- `PIPE_SKID_FLUSH_EN` undefined:
  - No `flush` port and no flush logic.

## Test plan
- Reset:
  - Hold `reset`=1 for 2 cycles with `in_valid`=1, `in_data`=74'h1F -> `in_ready`=0 throughout.
  - After release: `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=1.
- Streaming:
  - Send payloads 1, 2, 3, 4 on consecutive cycles with `out_ready`=1 -> `out_data` shows 1, 2, 3, 4 one cycle later.
  - `count` stays 1 and `in_ready` stays 1 throughout.
- Fill and stall:
  - With `out_ready`=0, offer 10, 11, 12 -> 10 and 11 are accepted, then `in_ready`=0 and `count`=2.
  - 12 is held upstream, `out_data`=10.
- Drain after stall:
  - From the fill-and-stall state, raise `out_ready` -> outputs 10, 11, 12 appear in order with no gap.
  - `in_ready` returns to 1 one cycle after the first `out_xfer`.
- Reset mid-operation:
  - In TWO (holding 10, 11), assert `reset` for one cycle -> `count`=0, `out_valid`=0.
  - The next payload 20 emerges as the first output.
- Flush (with `PIPE_SKID_FLUSH_EN`):
  - In TWO, assert `flush` while offering 30 -> EMPTY next cycle and 30 is dropped.
  - The following payload 31 is output with `count`=1.

Source files
------------

// File: rtl/pipe_skid_buffer_if.sv
// Handshake bundle for pipe_skid_buffer: upstream valid/ready/data, downstream valid/ready/data, occupancy.
// The flush signal exists only when PIPE_SKID_FLUSH_EN is defined.
interface pipe_skid_buffer_if #(
  parameter int WIDTH = 74
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       count;
`ifdef PIPE_SKID_FLUSH_EN
  logic             flush;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
`endif
endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer between pipeline stages; optional flush via PIPE_SKID_FLUSH_EN.
// Latency: one cycle from in_xfer to out_valid/out_data.
// Backpressure: in_ready depends on registered state only, so out_ready never reaches in_ready.
module pipe_skid_buffer #(
  parameter int WIDTH = 74
) (
  input  logic                clk,
  input  logic                reset,
  pipe_skid_buffer_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] m_dat;
  logic [WIDTH-1:0] s_dat;
  logic             load_m;
  logic             load_s;
  logic             m_from_s;
  logic             in_xfer;
  logic             out_xfer;

  assign bus.in_ready  = (state != TWO) & ~reset;
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = m_dat;
  assign bus.count     = state;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_m    = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_m = 1'b1;
        end else if (in_xfer) begin
          load_s    = 1'b1;
          state_nxt = TWO;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // Skid entry moves up; upstream is already stalled here.
        if (out_xfer) begin
          load_m    = 1'b1;
          m_from_s  = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
`ifdef PIPE_SKID_FLUSH_EN
    // Flush drops both entries and any same-cycle input; payload registers keep stale data.
    if (bus.flush) begin
      state_nxt = EMPTY;
      load_m    = 1'b0;
      load_s    = 1'b0;
      m_from_s  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      m_dat <= '0;
      s_dat <= '0;
    end else begin
      state <= state_nxt;
      if (load_m) begin
        m_dat <= m_from_s ? s_dat : bus.in_data;
      end
      if (load_s) begin
        s_dat <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed bench for pipe_skid_buffer: reset, streaming, fill/stall, drain, mid-stream reset and flush.
module tb_pipe_skid_buffer;
  localparam int W = 74;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pipe_skid_buffer_if #(.WIDTH(W)) sb_if ();

  pipe_skid_buffer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset              = 1'b1;
    sb_if.in_valid     = 1'b1;
    sb_if.in_data      = W'(74'h1F);
    sb_if.out_ready    = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    sb_if.flush        = 1'b0;
`endif
    #1;
    chk("rst_in_ready_c0", W'(sb_if.in_ready), W'(0));
    tick();
    chk("rst_in_ready_c1", W'(sb_if.in_ready), W'(0));
    tick();
    chk("rst_in_ready_c2", W'(sb_if.in_ready), W'(0));
    chk("rst_out_valid",   W'(sb_if.out_valid), W'(0));
    reset          = 1'b0;
    sb_if.in_valid = 1'b0;
    #1;
    chk("rel_out_valid", W'(sb_if.out_valid), W'(0));
    chk("rel_out_data",  sb_if.out_data, W'(0));
    chk("rel_count",     W'(sb_if.count), W'(0));
    chk("rel_in_ready",  W'(sb_if.in_ready), W'(1));

    // Streaming: 1..4 back to back with consumer ready.
    sb_if.out_ready = 1'b1;
    sb_if.in_valid  = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      sb_if.in_data = W'(v);
      tick();
      chk("stream_data",     sb_if.out_data, W'(v));
      chk("stream_valid",    W'(sb_if.out_valid), W'(1));
      chk("stream_count",    W'(sb_if.count), W'(1));
      chk("stream_in_ready", W'(sb_if.in_ready), W'(1));
    end
    sb_if.in_valid = 1'b0;
    tick();
    chk("stream_end_count", W'(sb_if.count), W'(0));
    chk("stream_end_valid", W'(sb_if.out_valid), W'(0));

    // Fill and stall: 10, 11 accepted, 12 held upstream.
    sb_if.out_ready = 1'b0;
    sb_if.in_valid  = 1'b1;
    sb_if.in_data   = W'(10);
    tick();
    chk("fill1_count",    W'(sb_if.count), W'(1));
    chk("fill1_in_ready", W'(sb_if.in_ready), W'(1));
    chk("fill1_data",     sb_if.out_data, W'(10));
    sb_if.in_data = W'(11);
    tick();
    chk("fill2_count",    W'(sb_if.count), W'(2));
    chk("fill2_in_ready", W'(sb_if.in_ready), W'(0));
    chk("fill2_data",     sb_if.out_data, W'(10));
    sb_if.in_data = W'(12);
    tick();
    chk("stall_count",    W'(sb_if.count), W'(2));
    chk("stall_in_ready", W'(sb_if.in_ready), W'(0));
    chk("stall_data",     sb_if.out_data, W'(10));

    // Drain: 10, 11, 12 with no gap; in_ready returns after the first out_xfer.
    sb_if.out_ready = 1'b1;
    #1;
    chk("drain0_data",  sb_if.out_data, W'(10));
    chk("drain0_valid", W'(sb_if.out_valid), W'(1));
    tick();
    chk("drain1_data",     sb_if.out_data, W'(11));
    chk("drain1_in_ready", W'(sb_if.in_ready), W'(1));
    chk("drain1_count",    W'(sb_if.count), W'(1));
    tick();
    chk("drain2_data",  sb_if.out_data, W'(12));
    chk("drain2_count", W'(sb_if.count), W'(1));
    sb_if.in_valid = 1'b0;
    tick();
    chk("drain3_valid", W'(sb_if.out_valid), W'(0));

    // Reset while holding two entries.
    sb_if.out_ready = 1'b0;
    sb_if.in_valid  = 1'b1;
    sb_if.in_data   = W'(10);
    tick();
    sb_if.in_data = W'(11);
    tick();
    chk("midrst_pre_count", W'(sb_if.count), W'(2));
    reset          = 1'b1;
    sb_if.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst_count", W'(sb_if.count), W'(0));
    chk("midrst_valid", W'(sb_if.out_valid), W'(0));
    chk("midrst_data",  sb_if.out_data, W'(0));
    sb_if.in_valid = 1'b1;
    sb_if.in_data  = W'(20);
    tick();
    chk("midrst_next_data",  sb_if.out_data, W'(20));
    chk("midrst_next_count", W'(sb_if.count), W'(1));
    sb_if.in_valid  = 1'b0;
    sb_if.out_ready = 1'b1;
    tick();
    chk("midrst_empty", W'(sb_if.count), W'(0));

`ifdef PIPE_SKID_FLUSH_EN
    // Flush in TWO while 30 is offered.
    sb_if.out_ready = 1'b0;
    sb_if.in_valid  = 1'b1;
    sb_if.in_data   = W'(28);
    tick();
    sb_if.in_data = W'(29);
    tick();
    sb_if.in_data = W'(30);
    sb_if.flush   = 1'b1;
    tick();
    sb_if.flush = 1'b0;
    chk("flush_count", W'(sb_if.count), W'(0));
    chk("flush_valid", W'(sb_if.out_valid), W'(0));
    sb_if.in_data = W'(31);
    tick();
    chk("flush_next_data",  sb_if.out_data, W'(31));
    chk("flush_next_count", W'(sb_if.count), W'(1));
    // Flush in ONE drops the same-cycle input even though in_ready is high.
    sb_if.in_data = W'(32);
    sb_if.flush   = 1'b1;
    #1;
    chk("flush_one_in_ready", W'(sb_if.in_ready), W'(1));
    tick();
    sb_if.flush    = 1'b0;
    sb_if.in_valid = 1'b0;
    chk("flush_one_count", W'(sb_if.count), W'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
